// File: rtl/mux_arbiter.sv
// Two-requester round-robin arbiter with a starvation hold limit that drives a
// shared registered output from the current owner's data.
module mux_arbiter #(
   parameter int WIDTH    = 16,
   parameter int MAX_HOLD = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_a,
   input  logic [WIDTH-1:0] a_data,
   input  logic             req_b,
   input  logic [WIDTH-1:0] b_data,
   output logic             grant_a,
   output logic             grant_b,
   output logic             sel,
   output logic [WIDTH-1:0] out,
   output logic             out_valid
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT_A = 2'd1,
      GRANT_B = 2'd2
   } state_t;

   localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

   state_t     state, next_state;
   logic       last_owner_b;
   logic [7:0] hold_cnt;
   logic       entry;

   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (req_a && req_b)
               next_state = last_owner_b ? GRANT_A : GRANT_B;
            else if (req_a)
               next_state = GRANT_A;
            else if (req_b)
               next_state = GRANT_B;
         end
         GRANT_A: begin
            if (!req_a)
               next_state = req_b ? GRANT_B : IDLE;
            else if (req_b && hold_cnt == HOLD_LAST)
               next_state = GRANT_B;
         end
         GRANT_B: begin
            if (!req_b)
               next_state = req_a ? GRANT_A : IDLE;
            else if (req_a && hold_cnt == HOLD_LAST)
               next_state = GRANT_A;
         end
         default: next_state = IDLE;
      endcase
   end

   assign entry = (next_state != IDLE) && (next_state != state);

   // sel and last_owner only change when a grant is newly taken, so sel holds through IDLE
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         last_owner_b <= 1'b1;
         hold_cnt     <= '0;
         sel          <= 1'b0;
      end else begin
         state <= next_state;
         if (entry) begin
            hold_cnt     <= '0;
            last_owner_b <= (next_state == GRANT_B);
            sel          <= (next_state == GRANT_B);
         end else if (state != IDLE && hold_cnt != HOLD_LAST) begin
            hold_cnt <= hold_cnt + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out       <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         if (state == GRANT_A && req_a) begin
            out       <= a_data;
            out_valid <= 1'b1;
         end else if (state == GRANT_B && req_b) begin
            out       <= b_data;
            out_valid <= 1'b1;
         end
      end
   end

   assign grant_a = (state == GRANT_A);
   assign grant_b = (state == GRANT_B);

endmodule

// File: tb/tb_mux_arbiter.sv
// Self-checking bench for mux_arbiter: directed scenarios plus randomized traffic
// compared against an owner/wait-time reference model.
module tb_mux_arbiter;

   localparam int WIDTH    = 16;
   localparam int MAX_HOLD = 8;

   logic             clk = 1'b0;
   logic             reset;
   logic             req_a, req_b;
   logic [WIDTH-1:0] a_data, b_data;
   logic             grant_a, grant_b, sel, out_valid;
   logic [WIDTH-1:0] out;

   always #5 clk = ~clk;

   mux_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
      .clk(clk), .reset(reset),
      .req_a(req_a), .a_data(a_data),
      .req_b(req_b), .b_data(b_data),
      .grant_a(grant_a), .grant_b(grant_b), .sel(sel),
      .out(out), .out_valid(out_valid)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: owner 0 = nobody, 1 = A, 2 = B; held counts whole cycles in the grant
   int               m_owner, m_held, m_last;
   logic             m_sel, m_valid;
   logic [WIDTH-1:0] m_out;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
   endtask

   task automatic model_reset();
      m_owner = 0; m_held = 0; m_last = 2;
      m_sel = 1'b0; m_valid = 1'b0; m_out = '0;
   endtask

   task automatic check_all(input string tag);
      check({tag, ".grant_a"},   32'(grant_a),   32'(m_owner == 1));
      check({tag, ".grant_b"},   32'(grant_b),   32'(m_owner == 2));
      check({tag, ".sel"},       32'(sel),       32'(m_sel));
      check({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
      check({tag, ".out"},       32'(out),       32'(m_out));
   endtask

   // Advance one clock: predict from the inputs in force at the edge, then compare.
   task automatic cycle(input string tag);
      int   nxt;
      logic own_req, oth_req;
      int   other;
      if (m_owner == 0) begin
         if (req_a && req_b) nxt = (m_last == 1) ? 2 : 1;
         else if (req_a)     nxt = 1;
         else if (req_b)     nxt = 2;
         else                nxt = 0;
      end else begin
         own_req = (m_owner == 1) ? req_a : req_b;
         oth_req = (m_owner == 1) ? req_b : req_a;
         other   = 3 - m_owner;
         if (!own_req)                            nxt = oth_req ? other : 0;
         else if (oth_req && m_held >= MAX_HOLD - 1) nxt = other;
         else                                      nxt = m_owner;
      end
      @(posedge clk);
      if (m_owner == 1 && req_a)      begin m_out = a_data; m_valid = 1'b1; end
      else if (m_owner == 2 && req_b) begin m_out = b_data; m_valid = 1'b1; end
      else                            m_valid = 1'b0;
      if (nxt != 0 && nxt != m_owner) begin
         m_held = 0;
         m_last = nxt;
         m_sel  = (nxt == 2);
      end else begin
         m_held++;
      end
      m_owner = nxt;
      #1;
      check_all(tag);
   endtask

   // Called 1 time unit after an edge; reset lands mid-cycle and releases on the falling edge.
   task automatic do_reset();
      reset = 1'b1;
      #3;
      model_reset();
      check_all("reset");
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; req_a = 1'b0; req_b = 1'b0; a_data = '0; b_data = '0;
      #1;
      do_reset();

      // Tie straight out of reset goes to A, data one edge later
      req_a = 1'b1; req_b = 1'b1; a_data = 16'h1111; b_data = 16'h5a5a;
      cycle("tie1");
      check("tie.grant_a", 32'(grant_a), 32'd1);
      check("tie.sel", 32'(sel), 32'd0);
      cycle("tie2");
      check("tie.out", 32'(out), 32'h1111);
      check("tie.valid", 32'(out_valid), 32'd1);

      // Release handover with no idle gap
      req_a = 1'b0; b_data = 16'h2222;
      cycle("hand1");
      check("hand.grant_b", 32'(grant_b), 32'd1);
      check("hand.sel", 32'(sel), 32'd1);
      cycle("hand2");
      check("hand.out", 32'(out), 32'h2222);
      check("hand.valid", 32'(out_valid), 32'd1);

      // Both held high: grants alternate in blocks of MAX_HOLD
      @(posedge clk); #1;
      do_reset();
      req_a = 1'b1; req_b = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         a_data = 16'(k); b_data = 16'(k + 16'h100);
         cycle("starve");
         check("starve.grant_a", 32'(grant_a), 32'(((k - 1) / MAX_HOLD) % 2 == 0));
         if (k >= 2) check("starve.valid", 32'(out_valid), 32'd1);
      end

      // Lone requester B keeps the grant, then A takes over on the next edge
      @(posedge clk); #1;
      do_reset();
      req_a = 1'b0; req_b = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         b_data = 16'($urandom);
         cycle("lone");
         check("lone.grant_b", 32'(grant_b), 32'd1);
      end
      req_a = 1'b1; a_data = 16'h3333;
      cycle("lone_a");
      check("lone.grant_a", 32'(grant_a), 32'd1);

      // Both low: idle, sel and out hold
      req_a = 1'b0; req_b = 1'b0;
      cycle("idle1");
      cycle("idle2");

      // Reset asserted between edges while B owns the output
      req_b = 1'b1;
      cycle("preb1");
      cycle("preb2");
      cycle("preb3");
      do_reset();
      check("midrst.grant_b", 32'(grant_b), 32'd0);

      // Randomized traffic with occasional resets
      for (int k = 0; k < 600; k++) begin
         req_a  = ($urandom_range(99) < 65);
         req_b  = ($urandom_range(99) < 55);
         a_data = 16'($urandom);
         b_data = 16'($urandom);
         cycle("rand");
         if ($urandom_range(149) == 0) do_reset();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1);
   end

endmodule

// File: doc/mux_arbiter.md
MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16: data width of each requester and of the output.
REQ-002 The block SHALL have parameter MAX_HOLD, default 8: the maximum number of consecutive grant cycles while the other requester waits; legal range 2..255.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port req_a, input, 1 bit: requester A asks for the shared output.
REQ-006 The block SHALL have port a_data, input, WIDTH bits: requester A data.
REQ-007 The block SHALL have port req_b, input, 1 bit: requester B asks for the shared output.
REQ-008 The block SHALL have port b_data, input, WIDTH bits: requester B data.
REQ-009 The block SHALL have port grant_a, output, 1 bit: A currently owns the output.
REQ-010 The block SHALL have port grant_b, output, 1 bit: B currently owns the output.
REQ-011 The block SHALL have port sel, output, 1 bit: mux select, 0 = A, 1 = B.
REQ-012 The block SHALL have port out, output, WIDTH bits: registered data of the owner.
REQ-013 The block SHALL have port out_valid, output, 1 bit: out holds data captured from an active owner.

Function
REQ-014 The FSM SHALL have states IDLE, GRANT_A and GRANT_B; grant_a = (state==GRANT_A) and grant_b = (state==GRANT_B), both decoded from the registered state (Moore).
REQ-015 The block SHALL keep a last_owner register that is updated on every entry into a grant state.
REQ-016 IDLE, req_a only: next state GRANT_A; req_b only: next state GRANT_B; neither: stay in IDLE.
REQ-017 IDLE, req_a and req_b both high: grant goes to the requester that is not last_owner (round-robin).
REQ-018 GRANT_x, req_x dropped: the block SHALL go to GRANT_other if the other requester is requesting, else to IDLE; there is no dead cycle on handover.
REQ-019 The hold counter SHALL clear on every grant entry and increment each cycle in a grant state, saturating at MAX_HOLD-1.
REQ-020 GRANT_x, req_x still high, other requesting and hold counter == MAX_HOLD-1: the block SHALL force a switch to GRANT_other on the next edge.
REQ-021 GRANT_x, req_x high, other not requesting: the block SHALL stay in GRANT_x indefinitely, with the counter saturated.
REQ-022 If the other requester arrives while the counter is saturated, the switch SHALL occur on the next edge.
REQ-023 sel SHALL be 0 in GRANT_A and 1 in GRANT_B, and SHALL hold its last value in IDLE.
REQ-024 When the FSM is in GRANT_x and req_x is high, out SHALL capture x_data at that edge and out_valid SHALL be 1 in the following cycle (one-cycle latency).
REQ-025 When the FSM is in IDLE, or the owner's req is low, out_valid SHALL be 0 next cycle and out SHALL hold its value.
REQ-026 Data SHALL never be captured from the non-owner, including on the handover cycle.

Reset
REQ-027 Asserting reset SHALL take effect immediately, independent of clk, at any point including mid-grant.
REQ-028 Reset values: state=IDLE, last_owner=B (so A wins the first tie), hold counter=0, grant_a=0, grant_b=0, sel=0, out=0, out_valid=0.
REQ-029 After reset is released, the first decision SHALL be made on the next rising edge per REQ-016/017.

Verification
REQ-030 Tie from reset: req_a=req_b=1, a_data=16'h1111 -> grant_a=1 at edge 1, sel=0, out=16'h1111 with out_valid=1 at edge 2.
REQ-031 Release handover: GRANT_A, drop req_a while req_b=1, b_data=16'h2222 -> grant_b=1 and sel=1 at the next edge, and out=16'h2222 one edge later with no IDLE cycle in between.
REQ-032 Starvation guard: req_a and req_b held high continuously -> grants alternate every 8 cycles (MAX_HOLD=8) and out_valid stays 1 throughout.
REQ-033 Lone requester: req_b held high alone for 20 cycles -> grant_b stays 1 for all 20; raise req_a at cycle 20 -> grant_a=1 at the next edge.
REQ-034 Reset mid-grant: assert reset between edges during GRANT_B -> grant_b=0, sel=0, out_valid=0 before the next edge.
REQ-035 Idle: both reqs low -> grants 0, out_valid 0 at the next edge, out and sel hold their last values.
